ct_butterfly_pipe: RTL and testbench

Forward-NTT Cooley-Tukey butterfly with valid/tag tracking. Per beat, it computes outa = (a + b·ROU) mod q and outb = (a − b·ROU) mod q. It is the forward-direction counterpart of the inverse-NTT Gentleman-Sande butterfly. It sits in the forward NTT datapath between the coefficient buffer read port and the write-back port. It carries a valid bit and a coefficient tag alongside the data so the write-back logic needs no external latency counter.

---
 rtl/fhe_pkg.sv | 7 +
 rtl/mod_add.sv | 16 +
 rtl/mod_mult.sv | 57 +++++
 rtl/mod_sub.sv | 12 +
 rtl/ct_butterfly_pipe.sv | 94 +++++++++
 tb/tb_ct_butterfly_pipe.sv | 216 +++++++++++++++++++++
 6 files changed

// File: rtl/fhe_pkg.sv
// Shared latency constants for the NTT butterflies.
// Both butterfly flavours and the NTT controllers take their timing from here.
package fhe_pkg;
  localparam int BFLY_MULT_LAT  = 9;
  localparam int BFLY_CT_LAT    = 11;
  localparam int BFLY_DEF_WIDTH = 16;
endpackage

// File: rtl/mod_add.sv
// Modular addition of two operands already reduced below q.
module mod_add #(
  parameter int BIT_WIDTH = 16
) (
  input  logic [BIT_WIDTH-1:0] x,
  input  logic [BIT_WIDTH-1:0] y,
  input  logic [BIT_WIDTH-1:0] q,
  output logic [BIT_WIDTH-1:0] z
);
  logic [BIT_WIDTH:0] s;
  logic [BIT_WIDTH:0] qx;

  assign s  = {1'b0, x} + {1'b0, y};
  assign qx = {1'b0, q};
  assign z  = BIT_WIDTH'((s >= qx) ? s - qx : s);
endmodule

// File: rtl/mod_mult.sv
// Pipelined Barrett modular multiplier, fixed BFLY_MULT_LAT cycle latency.
module mod_mult
  import fhe_pkg::*;
#(
  parameter int MAX_BIT_WIDTH = BFLY_DEF_WIDTH
) (
  input  logic                     clk,
  input  logic [MAX_BIT_WIDTH-1:0] x,
  input  logic [MAX_BIT_WIDTH-1:0] y,
  input  logic [MAX_BIT_WIDTH-1:0] q,
  input  logic [MAX_BIT_WIDTH:0]   m,
  input  logic [6:0]               k2,
  output logic [MAX_BIT_WIDTH-1:0] z
);
  localparam int W   = MAX_BIT_WIDTH;
  localparam int DW  = 2 * W;
  localparam int DW1 = 2 * W + 1;
  localparam int PW  = 3 * W + 1;
  localparam int QW  = W + 1;
  localparam int RW  = W + 2;
  localparam int PAD = BFLY_MULT_LAT - 7;

  logic [DW-1:0]  p1, p2, p3, p4;
  logic [PW-1:0]  pm2;
  logic [QW-1:0]  qh3;
  logic [DW1-1:0] qq4;
  logic [RW-1:0]  r5, r6, qx;
  logic [W-1:0]   r7;

  (* shreg_extract = "no" *) logic [W-1:0] pad [PAD];

  assign qx = {2'b00, q};

  // Quotient estimate is at most two short, so two conditional subtracts.
  always_ff @(posedge clk) begin
    p1  <= DW'(x) * DW'(y);
    pm2 <= PW'(p1) * PW'(m);
    p2  <= p1;
    qh3 <= QW'(pm2 >> k2);
    p3  <= p2;
    qq4 <= DW1'(qh3) * DW1'(q);
    p4  <= p3;
    r5  <= RW'({1'b0, p4} - qq4);
    r6  <= (r5 >= qx) ? r5 - qx : r5;
    r7  <= W'((r6 >= qx) ? r6 - qx : r6);
  end

  for (genvar i = 0; i < PAD; i++) begin : g_pad
    if (i == 0) begin : g_first
      always_ff @(posedge clk) pad[i] <= r7;
    end else begin : g_rest
      always_ff @(posedge clk) pad[i] <= pad[i-1];
    end
  end

  assign z = pad[PAD-1];
endmodule

// File: rtl/mod_sub.sv
// Modular subtraction of two operands already reduced below q.
module mod_sub #(
  parameter int BIT_WIDTH = 16
) (
  input  logic [BIT_WIDTH-1:0] x,
  input  logic [BIT_WIDTH-1:0] y,
  input  logic [BIT_WIDTH-1:0] q,
  output logic [BIT_WIDTH-1:0] z
);
  // The borrow case wraps mod 2^W, then adding q lands back in [0, q).
  assign z = (x >= y) ? x - y : x - y + q;
endmodule

// File: rtl/ct_butterfly_pipe.sv
// Forward-NTT Cooley-Tukey butterfly: outa = a + b*w, outb = a - b*w (mod q).
// Valid and tag ride alongside the data so write-back needs no latency counter.
module ct_butterfly_pipe
  import fhe_pkg::*;
#(
  parameter int BIT_WIDTH = BFLY_DEF_WIDTH,
  parameter int TAG_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic [BIT_WIDTH-1:0] ROU_entry,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic [BIT_WIDTH-1:0] q,
  input  logic [BIT_WIDTH:0]   m,
  input  logic [6:0]           k2,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] outa,
  output logic [BIT_WIDTH-1:0] outb,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);
  localparam int D = BFLY_CT_LAT - 1;

  (* shreg_extract = "no" *) logic [BIT_WIDTH-1:0] a_dly [D];
  (* shreg_extract = "no" *) logic [TAG_WIDTH-1:0] tag_dly [D];
  (* shreg_extract = "no" *) logic [D-1:0]         vld;

  logic [BIT_WIDTH-1:0] b_r, rou_r, t, sum, dif;

  always_ff @(posedge clk) begin
    b_r        <= b;
    rou_r      <= ROU_entry;
    a_dly[0]   <= a;
    tag_dly[0] <= in_tag;
  end

  for (genvar i = 1; i < D; i++) begin : g_dly
    always_ff @(posedge clk) begin
      a_dly[i]   <= a_dly[i-1];
      tag_dly[i] <= tag_dly[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld <= '0;
    else     vld <= {vld[D-2:0], in_valid};
  end

  mod_mult #(.MAX_BIT_WIDTH(BIT_WIDTH)) u_mult (
    .clk (clk),
    .x   (b_r),
    .y   (rou_r),
    .q   (q),
    .m   (m),
    .k2  (k2),
    .z   (t)
  );

  mod_add #(.BIT_WIDTH(BIT_WIDTH)) u_add (
    .x (a_dly[D-1]),
    .y (t),
    .q (q),
    .z (sum)
  );

  mod_sub #(.BIT_WIDTH(BIT_WIDTH)) u_sub (
    .x (a_dly[D-1]),
    .y (t),
    .q (q),
    .z (dif)
  );

  // Outputs only move on a real beat; bubbles leave the last result in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      outa      <= '0;
      outb      <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= vld[D-1];
      if (vld[D-1]) begin
        outa    <= sum;
        outb    <= dif;
        out_tag <= tag_dly[D-1];
      end
    end
  end

  assign busy = (|vld) | out_valid;
endmodule

// File: tb/tb_ct_butterfly_pipe.sv
// Randomised scoreboard bench for the CT butterfly pipeline.
module tb_ct_butterfly_pipe;
  localparam int W   = 16;
  localparam int TW  = 10;
  localparam int LAT = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  a = '0, b = '0, rou = '0, q = '0;
  logic [W:0]    m = '0;
  logic [6:0]    k2 = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid, busy;
  logic [W-1:0]  outa, outb;
  logic [TW-1:0] out_tag;

  typedef struct packed {
    logic [W-1:0]  ea;
    logic [W-1:0]  eb;
    logic [TW-1:0] et;
  } exp_t;

  exp_t          sb[$];
  bit            issued [8192];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [W-1:0]  hold_a = '0, hold_b = '0;
  logic [TW-1:0] hold_t = '0;

  ct_butterfly_pipe #(.BIT_WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .ROU_entry (rou),
    .in_tag    (in_tag),
    .q         (q),
    .m         (m),
    .k2        (k2),
    .out_valid (out_valid),
    .outa      (outa),
    .outb      (outb),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic exp_t model(logic [W-1:0] av, logic [W-1:0] bv,
                                 logic [W-1:0] rv, logic [TW-1:0] tv);
    exp_t   e;
    longint lq = longint'(q);
    longint pr = (longint'(bv) * longint'(rv)) % lq;
    e.ea = W'((longint'(av) + pr) % lq);
    e.eb = W'((longint'(av) - pr + lq) % lq);
    e.et = tv;
    return e;
  endfunction

  // Cycle-level model: a beat issued in cycle c is in flight for
  // cycles c+1..c+11 and is on the outputs in cycle c+11.
  always @(negedge clk) begin
    bit   ev;
    bit   eb;
    exp_t e;
    ev = (cyc >= LAT) && issued[cyc-LAT];
    eb = 1'b0;
    for (int c = cyc - LAT; c < cyc; c++)
      if (c >= 0 && issued[c]) eb = 1'b1;
    chk("out_valid", longint'(out_valid), longint'(ev));
    chk("busy", longint'(busy), longint'(eb));
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got out_valid=1 expected empty queue (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("outa", longint'(outa), longint'(e.ea));
        chk("outb", longint'(outb), longint'(e.eb));
        chk("out_tag", longint'(out_tag), longint'(e.et));
        hold_a = e.ea;
        hold_b = e.eb;
        hold_t = e.et;
      end
    end else begin
      chk("hold_outa", longint'(outa), longint'(hold_a));
      chk("hold_outb", longint'(outb), longint'(hold_b));
      chk("hold_tag", longint'(out_tag), longint'(hold_t));
    end
  end

  task automatic drive(input bit v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] rv, input logic [TW-1:0] tv);
    @(posedge clk);
    #1;
    in_valid = v;
    a        = av;
    b        = bv;
    rou      = rv;
    in_tag   = tv;
    if (v) begin
      issued[cyc] = 1'b1;
      sb.push_back(model(av, bv, rv, tv));
    end
  endtask

  task automatic rbeat();
    drive(1'b1, W'($urandom_range(int'(q) - 1, 0)), W'($urandom_range(int'(q) - 1, 0)),
          W'($urandom_range(int'(q) - 1, 0)), TW'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, W'($urandom), W'($urandom), W'($urandom), TW'($urandom));
  endtask

  task automatic load_q(input logic [W-1:0] qv);
    int     k;
    longint mm;
    k = 0;
    while ((qv >> k) != 0) k++;
    mm = (longint'(1) << (2 * k)) / longint'(qv);
    q  = qv;
    k2 = 7'(2 * k);
    m  = (W+1)'(mm);
  endtask

  task automatic change_q(input logic [W-1:0] qv);
    idle(LAT + 2);
    #1;
    chk("busy_before_q_change", longint'(busy), 0);
    load_q(qv);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    foreach (issued[i]) issued[i] = 1'b0;
    sb.delete();
    hold_a = '0;
    hold_b = '0;
    hold_t = '0;
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_outa", longint'(outa), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [W-1:0] sweep [3];

  initial begin
    load_q(W'(12289));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    drive(1'b1, W'(5), W'(3), W'(2), TW'(7));
    idle(LAT + 2);
    drive(1'b1, W'(12288), W'(1), W'(1), TW'(9));
    idle(LAT + 2);

    repeat (64) rbeat();
    repeat (6) begin
      rbeat();
      idle(3);
    end
    repeat (8) rbeat();
    idle(LAT + 3);

    idle(10);

    repeat (5) rbeat();
    pulse_reset();
    idle(15);
    rbeat();
    idle(LAT + 3);

    sweep[0] = W'(40961);
    sweep[1] = W'(65521);
    sweep[2] = W'(65535);
    for (int s = 0; s < 3; s++) begin
      change_q(sweep[s]);
      drive(1'b1, sweep[s] - 1'b1, sweep[s] - 1'b1, sweep[s] - 1'b1, TW'(s + 100));
      repeat (12) rbeat();
      idle(2);
      repeat (4) rbeat();
    end
    idle(LAT + 3);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d beats left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
